// File: rtl/text_line_renderer_pkg.sv
// Shared constants and the glyph table behind tcgrom for the text line renderer.
package text_line_renderer_pkg;

  localparam int unsigned GlyphW    = 8;
  localparam int unsigned GlyphH    = 8;
  localparam int unsigned RomAw     = 9;
  localparam int unsigned RgbW      = 24;
  localparam int unsigned PipeDepth = 3;

  // Row 0 of each glyph sits in the most significant byte; bit 7 is the leftmost column.
  function automatic logic [7:0] glyph_row(input logic [5:0] code, input logic [2:0] row);
    logic [63:0] g;
    case (code)
      6'd0:    g = 64'h3C66_6E6E_6062_3C00; // @
      6'd1:    g = 64'h183C_667E_6666_6600; // A
      6'd2:    g = 64'h7C66_667C_6666_7C00; // B
      6'd3:    g = 64'h3C66_6060_6066_3C00; // C
      6'd4:    g = 64'h786C_6666_666C_7800; // D
      6'd5:    g = 64'h7E60_6078_6060_7E00; // E
      6'd6:    g = 64'h7E60_6078_6060_6000; // F
      6'd7:    g = 64'h3C66_606E_6666_3C00; // G
      6'd8:    g = 64'h6666_667E_6666_6600; // H
      6'd24:   g = 64'h6666_3C18_3C66_6600; // X
      default: g = 64'h0;
    endcase
    return g[8*(7-row) +: 8];
  endfunction

endpackage

// File: rtl/tcgrom.sv
// Character generator ROM: one glyph row per address {code, row}, registered read.
module tcgrom
  import text_line_renderer_pkg::*;
#(
  parameter int unsigned AW = RomAw
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data
);

  always_ff @(posedge clk) begin
    data <= glyph_row(6'(addr[AW-1:3]), addr[2:0]);
  end

endmodule

// File: rtl/text_cursor_blink.sv
// Cursor blink phase: toggles once every 2**BLINK_DIV frame_start pulses, 0 after reset.
module text_cursor_blink #(
  parameter int unsigned BLINK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic phase
);

  logic [BLINK_DIV-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/text_line_renderer.sv
// Draws a line of up to MAX_CHARS scaled 8x8 glyphs over the VGA stream, 3-cycle pipeline.
// Optional blinking inverted cursor cell when the CURSOR_EN macro is defined.
module text_line_renderer
  import text_line_renderer_pkg::*;
#(
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned CODE_W    = 6,
  parameter int unsigned BLINK_DIV = 5,
  localparam int unsigned SW       = $clog2(MAX_CHARS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [SW-1:0]     wr_addr,
  input  logic [CODE_W-1:0] wr_code,
  input  logic [SW:0]       str_len,
  input  logic [10:0]       vga_x,
  input  logic [9:0]        vga_y,
  input  logic              vga_valid,
  input  logic [10:0]       top_left_x,
  input  logic [9:0]        top_left_y,
  input  logic [1:0]        scale_x_sh,
  input  logic [1:0]        scale_y_sh,
  input  logic [RgbW-1:0]   fg_rgb,
  input  logic [SW-1:0]     cursor_pos,
  input  logic              frame_start,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              pix_valid,
  output logic              pix_hit
);

  // S0 address generation
  logic signed [11:0] dx;
  logic signed [10:0] dy;
  logic [10:0]        dx_u, sx_px;
  logic [9:0]         dy_u, sy_px;
  logic [SW:0]        len_c;
  logic [31:0]        line_w, glyph_h;
  logic [SW-1:0]      slot;
  logic               in_bounds;

  always_comb begin
    dx        = $signed({1'b0, vga_x}) - $signed({1'b0, top_left_x});
    dy        = $signed({1'b0, vga_y}) - $signed({1'b0, top_left_y});
    dx_u      = dx[10:0];
    dy_u      = dy[9:0];
    sx_px     = dx_u >> scale_x_sh;
    sy_px     = dy_u >> scale_y_sh;
    slot      = sx_px[SW+2:3];
    len_c     = (str_len > (SW+1)'(MAX_CHARS)) ? (SW+1)'(MAX_CHARS) : str_len;
    line_w    = 32'(len_c) << (3 + scale_x_sh);
    glyph_h   = 32'(GlyphH) << scale_y_sh;
    // Signed differences keep glyphs from wrapping around the screen edges.
    in_bounds = !dx[11] && !dy[10] && (32'(dx_u) < line_w) && (32'(dy_u) < glyph_h);
  end

  logic unused_bits;
  assign unused_bits = ^{sx_px[10:SW+3], sy_px[9:3]};

  logic cur_hit;
`ifdef CURSOR_EN
  logic phase;

  text_cursor_blink #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .phase      (phase)
  );

  assign cur_hit = phase && (slot == cursor_pos) && ({1'b0, cursor_pos} < len_c);
`else
  logic unused_cursor;
  assign cur_hit       = 1'b0;
  assign unused_cursor = ^{cursor_pos, frame_start};
`endif

  // String buffer, not reset; read-first so a same-edge write is seen one pixel later.
  logic [CODE_W-1:0] str_mem [MAX_CHARS];

  always_ff @(posedge clk) begin
    if (wr_en) str_mem[wr_addr] <= wr_code;
  end

  logic [CODE_W-1:0] code_q;
  logic [2:0]        row_q, col_q, col1_q;
  logic              inb_q, inb1_q, vld_q, vld1_q, en_q, en1_q, cur_q, cur1_q;
  logic [RgbW-1:0]   fg_q, fg1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      inb_q  <= 1'b0;
      vld_q  <= 1'b0;
      en_q   <= 1'b0;
      cur_q  <= 1'b0;
      fg_q   <= '0;
      col1_q <= '0;
      inb1_q <= 1'b0;
      vld1_q <= 1'b0;
      en1_q  <= 1'b0;
      cur1_q <= 1'b0;
      fg1_q  <= '0;
    end else begin
      code_q <= str_mem[slot];
      row_q  <= sy_px[2:0];
      col_q  <= sx_px[2:0];
      inb_q  <= in_bounds;
      vld_q  <= vga_valid;
      en_q   <= enable;
      cur_q  <= cur_hit;
      fg_q   <= fg_rgb;
      col1_q <= col_q;
      inb1_q <= inb_q;
      vld1_q <= vld_q;
      en1_q  <= en_q;
      cur1_q <= cur_q;
      fg1_q  <= fg_q;
    end
  end

  // S1 glyph row fetch
  logic [7:0] rom_data;

  tcgrom #(
    .AW(CODE_W + 3)
  ) u_rom (
    .clk (clk),
    .addr({code_q, row_q}),
    .data(rom_data)
  );

  // S2 pixel select and colour
  logic            pix_bit, hit;
  logic [RgbW-1:0] rgb_d;

  always_comb begin
    pix_bit = rom_data[3'd7 - col1_q] ^ cur1_q;
    hit     = inb1_q & vld1_q & pix_bit;
    rgb_d   = (hit && en1_q) ? fg1_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      pix_valid <= 1'b0;
      pix_hit   <= 1'b0;
    end else begin
      r         <= rgb_d[23:16];
      g         <= rgb_d[15:8];
      b         <= rgb_d[7:0];
      pix_valid <= vld1_q;
      pix_hit   <= hit;
    end
  end

endmodule

// File: tb/tb_text_line_renderer.sv
// Randomised self-checking bench for text_line_renderer against an arithmetic pixel model.
module tb_text_line_renderer;

`ifdef CURSOR_EN
  localparam int unsigned BlinkDiv = 1;
`else
  localparam int unsigned BlinkDiv = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [5:0]  wr_code = '0;
  logic [4:0]  str_len = '0;
  logic [10:0] vga_x = '0;
  logic [9:0]  vga_y = '0;
  logic        vga_valid = 1'b0;
  logic [10:0] top_left_x = '0;
  logic [9:0]  top_left_y = '0;
  logic [1:0]  scale_x_sh = '0;
  logic [1:0]  scale_y_sh = '0;
  logic [23:0] fg_rgb = 24'hFFFFFF;
  logic [3:0]  cursor_pos = '0;
  logic        frame_start = 1'b0;
  logic [7:0]  r, g, b;
  logic        pix_valid, pix_hit;

  text_line_renderer #(
    .MAX_CHARS(16),
    .CODE_W   (6),
    .BLINK_DIV(BlinkDiv)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_code    (wr_code),
    .str_len    (str_len),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_valid  (vga_valid),
    .top_left_x (top_left_x),
    .top_left_y (top_left_y),
    .scale_x_sh (scale_x_sh),
    .scale_y_sh (scale_y_sh),
    .fg_rgb     (fg_rgb),
    .cursor_pos (cursor_pos),
    .frame_start(frame_start),
    .r          (r),
    .g          (g),
    .b          (b),
    .pix_valid  (pix_valid),
    .pix_hit    (pix_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    bit          valid;
    bit          hit;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   model_buf[16];
  int   frame_pulses = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   codes[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 24, 32};

  function automatic logic [7:0] font_row(input int code, input int row);
    logic [7:0] f[8];
    case (code)
      0:       f = '{8'h3C, 8'h66, 8'h6E, 8'h6E, 8'h60, 8'h62, 8'h3C, 8'h00};
      1:       f = '{8'h18, 8'h3C, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00};
      2:       f = '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00};
      3:       f = '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00};
      4:       f = '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00};
      5:       f = '{8'h7E, 8'h60, 8'h60, 8'h78, 8'h60, 8'h60, 8'h7E, 8'h00};
      6:       f = '{8'h7E, 8'h60, 8'h60, 8'h78, 8'h60, 8'h60, 8'h60, 8'h00};
      7:       f = '{8'h3C, 8'h66, 8'h60, 8'h6E, 8'h66, 8'h66, 8'h3C, 8'h00};
      8:       f = '{8'h66, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00};
      24:      f = '{8'h66, 8'h66, 8'h3C, 8'h18, 8'h3C, 8'h66, 8'h66, 8'h00};
      default: f = '{default: 8'h00};
    endcase
    return f[row];
  endfunction

  function automatic bit cursor_phase();
`ifdef CURSOR_EN
    return ((frame_pulses >> BlinkDiv) & 1) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected hit for the inputs currently driven, from geometry alone.
  function automatic bit model_hit();
    int dx, dy, sx, sy, len, slot, col, row;
    logic [7:0] bits;
    bit bt;
    dx  = int'(vga_x) - int'(top_left_x);
    dy  = int'(vga_y) - int'(top_left_y);
    sx  = 1 << scale_x_sh;
    sy  = 1 << scale_y_sh;
    len = (int'(str_len) > 16) ? 16 : int'(str_len);
    if (!vga_valid || dx < 0 || dy < 0 || dy >= 8 * sy || dx >= len * 8 * sx) return 1'b0;
    slot = dx / (8 * sx);
    col  = (dx / sx) % 8;
    row  = dy / sy;
    bits = font_row(model_buf[slot], row);
    bt   = bits[7-col];
    if (cursor_phase() && slot == int'(cursor_pos) && int'(cursor_pos) < len) bt = ~bt;
    return bt;
  endfunction

  task automatic drive(input int x, input int y, input bit v, input bit we = 1'b0,
                       input int wa = 0, input int wc = 0, input bit fs = 1'b0);
    exp_t e;
    vga_x       = 11'(x);
    vga_y       = 10'(y);
    vga_valid   = v;
    wr_en       = we;
    wr_addr     = 4'(wa);
    wr_code     = 6'(wc);
    frame_start = fs;
    e.x     = x;
    e.y     = y;
    e.valid = v;
    e.hit   = model_hit();
    e.rgb   = (e.hit && enable) ? fg_rgb : 24'h0;
    q.push_back(e);
    if (we) model_buf[wa] = wc;
    if (fs) frame_pulses++;
  endtask

  task automatic tick(output exp_t e, output bit got);
    @(posedge clk);
    #1;
    got = 1'b0;
    if (q.size() >= 3) begin
      e   = q.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic load(input int slot, input int code);
    exp_t e;
    bit   got;
    tick(e, got);
    drive(0, 0, 1'b0, 1'b1, slot, code);
  endtask

  task automatic idle(input int n, input bit fs = 1'b0);
    exp_t e;
    bit   got;
    for (int i = 0; i < n; i++) begin
      tick(e, got);
      drive(0, 0, 1'b0, 1'b0, 0, 0, fs);
    end
  endtask

  task automatic sweep(input string name, input int x0, input int x1, input int y0, input int y1);
    exp_t e;
    bit   got;
    int   w, n;
    w = x1 - x0 + 1;
    n = w * (y1 - y0 + 1);
    for (int i = 0; i < n + 3; i++) begin
      tick(e, got);
      if (got) begin
        n_tests++;
        if ({pix_valid, pix_hit, r, g, b} !== {e.valid, e.hit, e.rgb}) begin
          n_fail++;
          $display("FAIL %s (%0d,%0d): valid=%b hit=%b rgb=%h, expected valid=%b hit=%b rgb=%h",
                   name, e.x, e.y, pix_valid, pix_hit, {r, g, b}, e.valid, e.hit, e.rgb);
        end
      end
      if (i < n) drive(x0 + i % w, y0 + i / w, 1'b1);
      else drive(0, 0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    vga_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({r, g, b} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_rgb: got %h, expected 000000", {r, g, b});
    end
    n_tests++;
    if (pix_valid !== 1'b0 || pix_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b hit=%b, expected 0 0", pix_valid, pix_hit);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) load(i, 32);
    idle(3);
  endtask

  task automatic test_two_glyphs();
    load(0, 1);
    load(1, 2);
    str_len    = 5'd2;
    scale_x_sh = 2'd0;
    scale_y_sh = 2'd0;
    top_left_x = 11'd40;
    top_left_y = 10'd20;
    fg_rgb     = 24'hFFFFFF;
    sweep("two_glyphs", 38, 58, 19, 29);
  endtask

  task automatic test_scaled();
    load(0, 5);
    str_len    = 5'd1;
    scale_x_sh = 2'd1;
    scale_y_sh = 2'd2;
    top_left_x = 11'd90;
    top_left_y = 10'd20;
    fg_rgb     = 24'h12AB34;
    sweep("scaled_E", 88, 108, 18, 54);
  endtask

  task automatic test_bounds();
    exp_t e;
    bit   got;
    int   px[3] = '{39, 56, 43};
    int   py[3] = '{20, 20, 28};
    load(0, 1);
    load(1, 2);
    str_len    = 5'd2;
    scale_x_sh = 2'd0;
    scale_y_sh = 2'd0;
    top_left_x = 11'd40;
    top_left_y = 10'd20;
    for (int i = 0; i < 6; i++) begin
      tick(e, got);
      if (got && e.valid) begin
        n_tests++;
        if (pix_hit !== 1'b0 || {r, g, b} !== 24'h0) begin
          n_fail++;
          $display("FAIL edge_miss (%0d,%0d): hit=%b rgb=%h, expected 0 000000",
                   e.x, e.y, pix_hit, {r, g, b});
        end
      end
      if (i < 3) drive(px[i], py[i], 1'b1);
      else drive(0, 0, 1'b0);
    end
    str_len = 5'd0;
    sweep("len_zero", 36, 60, 18, 30);
    for (int i = 0; i < 16; i++) load(i, codes[$urandom_range(0, 10)]);
    str_len = 5'd31;
    sweep("len_clamp", 150, 175, 19, 28);
    enable = 1'b0;
    sweep("disabled", 38, 50, 20, 22);
    enable = 1'b1;
  endtask

  task automatic test_write_collide();
    exp_t e;
    bit   got;
    bit   want[2] = '{1'b1, 1'b0};
    int   seen = 0;
    load(0, 1);
    str_len    = 5'd1;
    scale_x_sh = 2'd0;
    scale_y_sh = 2'd0;
    top_left_x = 11'd40;
    top_left_y = 10'd20;
    idle(3);
    for (int i = 0; i < 6; i++) begin
      tick(e, got);
      if (got && e.x == 43 && seen < 2) begin
        n_tests++;
        if (pix_hit !== want[seen] || pix_hit !== e.hit) begin
          n_fail++;
          $display("FAIL write_collide[%0d]: hit=%b, expected %b", seen, pix_hit, want[seen]);
        end
        seen++;
      end
      if (i == 0) drive(43, 20, 1'b1, 1'b1, 0, 24);
      else if (i == 1) drive(43, 20, 1'b1);
      else drive(0, 0, 1'b0);
    end
    n_tests++;
    if (seen != 2) begin
      n_fail++;
      $display("FAIL write_collide_count: saw %0d pixels, expected 2", seen);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   got;
    bit   want_hit;
    load(0, 1);
    str_len    = 5'd1;
    top_left_x = 11'd40;
    top_left_y = 10'd20;
    for (int i = 0; i < 4; i++) begin
      tick(e, got);
      drive(43, 20, 1'b1);
    end
    want_hit = model_hit();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pix_valid, pix_hit, r, g, b} !== 26'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: valid=%b hit=%b rgb=%h, expected all 0",
               pix_valid, pix_hit, {r, g, b});
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (pix_valid !== (i == 3) || pix_hit !== (i == 3 && want_hit)) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: valid=%b hit=%b, expected %b %b",
                 i, pix_valid, pix_hit, i == 3, i == 3 && want_hit);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit   got;
    int   len, w, h, x, y;
    for (int blk = 0; blk < 12; blk++) begin
      for (int k = 0; k < 3; k++) load($urandom_range(0, 15), codes[$urandom_range(0, 10)]);
      idle(3);
      for (int i = 0; i < 160; i++) begin
        tick(e, got);
        if (got) begin
          n_tests++;
          if ({pix_valid, pix_hit, r, g, b} !== {e.valid, e.hit, e.rgb}) begin
            n_fail++;
            $display("FAIL random (%0d,%0d): valid=%b hit=%b rgb=%h, expected %b %b %h",
                     e.x, e.y, pix_valid, pix_hit, {r, g, b}, e.valid, e.hit, e.rgb);
          end
        end
        if (i % 40 == 0) begin
          top_left_x = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1990, 2047))
                                                   : 11'($urandom_range(0, 1900));
          top_left_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023))
                                                   : 10'($urandom_range(0, 990));
          scale_x_sh = 2'($urandom_range(0, 3));
          scale_y_sh = 2'($urandom_range(0, 3));
          str_len    = 5'($urandom_range(0, 20));
          fg_rgb     = 24'($urandom);
          enable     = ($urandom_range(0, 3) != 0);
        end
        len = (int'(str_len) > 16) ? 16 : int'(str_len);
        w   = len * 8 * (1 << scale_x_sh);
        h   = 8 * (1 << scale_y_sh);
        x   = (int'(top_left_x) + $urandom_range(0, w + 8) - 4) & 2047;
        y   = (int'(top_left_y) + $urandom_range(0, h + 4) - 2) & 1023;
        drive(x, y, $urandom_range(0, 7) != 0);
      end
    end
    enable = 1'b1;
    fg_rgb = 24'hFFFFFF;
  endtask

  task automatic test_cursor();
    load(0, 1);
    load(1, 2);
    str_len    = 5'd2;
    scale_x_sh = 2'd0;
    scale_y_sh = 2'd0;
    top_left_x = 11'd40;
    top_left_y = 10'd20;
    cursor_pos = 4'd1;
    sweep("cursor_p0", 40, 55, 20, 27);
    idle(2, 1'b1);
    sweep("cursor_p2", 40, 55, 20, 27);
    idle(2, 1'b1);
    sweep("cursor_p4", 40, 55, 20, 27);
  endtask

  initial begin
    test_reset();
    test_two_glyphs();
    test_scaled();
    test_bounds();
    test_write_collide();
    test_random();
    test_reset_mid();
    sweep("after_reset", 38, 50, 20, 27);
    test_cursor();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
